// File: rtl/grant_dispatch.sv
// Dispatch stage behind the round-robin arbiter. It encodes the one-hot grant,
// captures the granted client's payload and buffers it in a 2-entry FIFO.
module grant_dispatch #(
  parameter int CLIENTS   = 32,
  parameter int CLIENTS_W = $clog2(CLIENTS),
  parameter int DATA_W    = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CLIENTS-1:0]        grant,
  input  logic [CLIENTS*DATA_W-1:0] client_data,
  output logic                      stall,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [CLIENTS_W-1:0]      out_client_id,
  output logic                      multi_grant_err
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]           count;
  logic [CLIENTS_W-1:0] id_q   [2];
  logic [DATA_W-1:0]    data_q [2];
  logic                 rd_ptr;
  logic                 wr_ptr;

  logic                 enc_found;
  logic [CLIENTS_W-1:0] enc_idx;
  logic [DATA_W-1:0]    enc_data;
  logic                 multi_hot;
  logic                 push;
  logic                 pop;

  // Lowest set grant bit wins; the payload is muxed alongside the index.
  always_comb begin
    enc_found = 1'b0;
    enc_idx   = '0;
    enc_data  = '0;
    for (int unsigned i = 0; i < CLIENTS; i++) begin
      if (grant[i] && !enc_found) begin
        enc_found = 1'b1;
        enc_idx   = CLIENTS_W'(i);
        enc_data  = client_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign multi_hot = |(grant & (grant - CLIENTS'(1)));

  assign stall     = (count == FULL);
  assign out_valid = (count != EMPTY);
  assign push      = enc_found & ~stall;
  assign pop       = out_valid & out_ready;

  // Popped slots keep stale contents, so the head is masked when empty.
  assign out_data      = out_valid ? data_q[rd_ptr] : '0;
  assign out_client_id = out_valid ? id_q[rd_ptr]   : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      count           <= EMPTY;
      rd_ptr          <= 1'b0;
      wr_ptr          <= 1'b0;
      multi_grant_err <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (push) begin
        id_q[wr_ptr]   <= enc_idx;
        data_q[wr_ptr] <= enc_data;
        wr_ptr         <= ~wr_ptr;
        if (multi_hot) multi_grant_err <= 1'b1;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case (count)
        EMPTY:   if (push) count <= ONE;
        ONE: begin
          if (push && !pop)      count <= FULL;
          else if (!push && pop) count <= EMPTY;
        end
        FULL:    if (pop) count <= ONE;
        default: count <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_dispatch.sv
// Directed table-driven bench for grant_dispatch plus streaming and capture-timing sequences.
module tb_grant_dispatch;

  localparam int CLIENTS   = 32;
  localparam int CLIENTS_W = 5;
  localparam int DATA_W    = 32;

  logic                      clock;
  logic                      reset;
  logic [CLIENTS-1:0]        grant;
  logic [CLIENTS*DATA_W-1:0] client_data;
  logic                      stall;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_data;
  logic [CLIENTS_W-1:0]      out_client_id;
  logic                      multi_grant_err;

  int n_cmp;
  int n_bad;

  grant_dispatch #(
    .CLIENTS   (CLIENTS),
    .CLIENTS_W (CLIENTS_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .grant           (grant),
    .client_data     (client_data),
    .stall           (stall),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_client_id   (out_client_id),
    .multi_grant_err (multi_grant_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [31:0] gnt;
    logic        rdy;
    logic        v;
    logic [4:0]  id;
    logic        st;
    logic        err;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic [31:0] gnt, input logic rdy,
                              input logic v, input logic [4:0] id, input logic st,
                              input logic err);
    vec_t r;
    r.rst = rst; r.gnt = gnt; r.rdy = rdy; r.v = v; r.id = id; r.st = st; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_default_data();
    for (int i = 0; i < CLIENTS; i++)
      client_data[i*DATA_W +: DATA_W] = 32'hA5A5_0000 | 32'(i);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    grant = '0;
    out_ready = 1'b0;
    set_default_data();

    // {reset, grant, out_ready} -> state visible after the edge
    vecs[0]  = mk(1'b1, 32'h0000_0010, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 32'h0000_0020, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 32'h0000_0008, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 32'h0000_0080, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0);
    vecs[5]  = mk(1'b0, 32'h0000_0200, 1'b0, 1'b1, 5'd3,  1'b1, 1'b0);
    vecs[6]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd7,  1'b0, 1'b0);
    vecs[7]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 32'h0000_0002, 1'b0, 1'b1, 5'd1,  1'b0, 1'b0);
    vecs[10] = mk(1'b0, 32'h0000_1000, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 32'h0000_0000, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[13] = mk(1'b0, 32'h0000_0410, 1'b1, 1'b1, 5'd4,  1'b0, 1'b1);
    vecs[14] = mk(1'b0, 32'h0000_0040, 1'b1, 1'b1, 5'd6,  1'b0, 1'b1);
    vecs[15] = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 1'b1);
    vecs[16] = mk(1'b0, 32'h0000_0004, 1'b0, 1'b1, 5'd2,  1'b0, 1'b1);
    vecs[17] = mk(1'b0, 32'h8000_0000, 1'b0, 1'b1, 5'd2,  1'b1, 1'b1);
    vecs[18] = mk(1'b1, 32'h0000_0100, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[19] = mk(1'b0, 32'h0000_0001, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0);
    vecs[20] = mk(1'b0, 32'h0000_0000, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0);
    vecs[21] = mk(1'b0, 32'h0010_0000, 1'b0, 1'b1, 5'd20, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 32'h0020_0000, 1'b0, 1'b1, 5'd20, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 32'h0000_0003, 1'b0, 1'b1, 5'd20, 1'b1, 1'b0);
    vecs[24] = mk(1'b0, 32'h0000_0000, 1'b1, 1'b1, 5'd21, 1'b0, 1'b0);

    step();
    step();

    for (int i = 0; i < NVEC; i++) begin
      logic [31:0] exp_data;
      reset     = vecs[i].rst;
      grant     = vecs[i].gnt;
      out_ready = vecs[i].rdy;
      step();
      exp_data = vecs[i].v ? (32'hA5A5_0000 | 32'(vecs[i].id)) : 32'h0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
      check($sformatf("vec%0d out_client_id", i), 32'(out_client_id), 32'(vecs[i].id));
      check($sformatf("vec%0d out_data", i), out_data, exp_data);
      check($sformatf("vec%0d stall", i), 32'(stall), 32'(vecs[i].st));
      check($sformatf("vec%0d multi_grant_err", i), 32'(multi_grant_err), 32'(vecs[i].err));
    end

    // Drain the last entry (client 21) left by the table.
    reset = 1'b0;
    grant = '0;
    out_ready = 1'b1;
    step();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Streaming: one grant per cycle, each visible the next cycle, never stalling.
    for (int k = 0; k < 40; k++) begin
      int c;
      c = (k * 5 + 1) % CLIENTS;
      grant = 32'h1 << c;
      out_ready = 1'b1;
      step();
      check($sformatf("stream%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d out_client_id", k), 32'(out_client_id), 32'(c));
      check($sformatf("stream%0d out_data", k), out_data, 32'hA5A5_0000 | 32'(c));
      check($sformatf("stream%0d stall", k), 32'(stall), 32'd0);
    end
    grant = '0;
    step();
    check("stream end out_valid", 32'(out_valid), 32'd0);

    // Payload is sampled in the grant cycle and held while out_ready is low.
    client_data[9*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    grant = 32'h0000_0200;
    out_ready = 1'b0;
    step();
    check("capture out_data", out_data, 32'hDEAD_BEEF);
    client_data[9*DATA_W +: DATA_W] = 32'h1234_5678;
    grant = '0;
    step();
    check("hold out_data", out_data, 32'hDEAD_BEEF);
    check("hold out_client_id", 32'(out_client_id), 32'd9);
    out_ready = 1'b1;
    step();
    check("capture drain out_valid", 32'(out_valid), 32'd0);
    set_default_data();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grant_dispatch.md
Name: grant_dispatch

Overview:
- Sits directly downstream of the round-robin arbiter (rr_arbiter).
- Consumes the arbiter's one-hot `grant`, encodes it to a client index and captures that client's payload.
- Buffers up to two dispatched transactions and presents them on a valid/ready output.
- Drives `stall` back to the arbiter when the buffer is full, so the arbiter holds its selection and leaves pending requests pending.

Parameters:
- CLIENTS, 32, number of arbiter clients; must match the arbiter instance.
- CLIENTS_W, $clog2(CLIENTS), width of the encoded client index.
- DATA_W, 32, payload width per client.

Ports:
- clock  input  1  single clock; all state updates on posedge clock.
- reset  input  1  synchronous, active-high reset.
- grant  input  CLIENTS  grant vector from the arbiter; expected one-hot or zero.
- client_data  input  CLIENTS*DATA_W  flattened payloads; client i occupies bits [i*DATA_W +: DATA_W].
- stall  output  1  to arbiter; high when the buffer cannot accept a grant.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  DATA_W  payload of the head entry.
- out_client_id  output  CLIENTS_W  encoded client index of the head entry.
- multi_grant_err  output  1  sticky flag; set when `grant` has more than one bit set.

Behaviour:
- Storage: 2-entry FIFO. Each entry holds {client_id, data}. Occupancy register `count` takes values 0, 1 or 2; states are EMPTY, ONE, FULL.
- Output decode:
  - `stall = (count == 2)`, decoded from the registered count; no combinational path from `grant` or `out_ready`.
  - `out_valid = (count != 0)`.
  - `out_data` / `out_client_id` always show the head entry, and are 0 when empty.
- Push: `push = (|grant) & ~stall`.
  - The entry captures the lowest set index of `grant` and `client_data[idx]` sampled in the same cycle.
  - `grant` presented while `stall` = 1 is ignored entirely: no capture, no error check. The arbiter re-presents the grant after stall drops.
- Pop: `pop = out_valid & out_ready`. The head retires at the clock edge.
- Next count = count + push − pop.
  - EMPTY: push → ONE; pop is impossible.
  - ONE: push & pop → ONE; push only → FULL; pop only → EMPTY.
  - FULL: pop → ONE; push is impossible because stall = 1.
- Latency:
  - A grant accepted in cycle N appears on `out_valid`/`out_data` in cycle N+1 if the buffer was empty at N.
  - Otherwise the entry appears after the older entry pops.
  - Order is strictly FIFO.
- Throughput: one transaction per cycle when `out_ready` is held high. Count settles at ONE with no stall.
- Multi-hot grant (popcount > 1, no stall):
  - Set `multi_grant_err`, which stays high until reset.
  - Still push one entry using the lowest set index.
- Zero grant: no push, no error.
- Output stability: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_client_id` do not change.
- Reset, including mid-operation:
  - Takes effect at the next posedge.
  - count → 0; out_valid, stall and multi_grant_err → 0; out_data and out_client_id → 0.
  - All buffered entries are discarded.
  - `grant` in the reset cycle is ignored.

Test Plan:
- Single grant: `grant = 1<<5`, `client_data[5] = 32'hA5A5_0005`, `out_ready = 1` → next cycle `out_valid = 1`, `out_client_id = 5`, `out_data = 32'hA5A5_0005`; the cycle after, `out_valid = 0`.
- Backpressure fill: `out_ready = 0`; grants to client 3 then client 7 in consecutive cycles.
  - Expect `stall = 1` from the cycle after the second push.
  - A grant to client 9 during stall is ignored.
  - Raise `out_ready` → outputs 3, then 7; stall drops after the first pop; client 9 is never output unless re-granted.
- Streaming: grant a different client every cycle for 40 cycles with `out_ready = 1` → `stall` never asserts; 40 outputs in grant order, each 1 cycle after its grant.
- Simultaneous push/pop at ONE: count = 1, push client 12 and pop in the same cycle → count stays 1; head becomes client 12 next cycle.
- Multi-hot: `grant = 32'h0000_0410` (bits 4 and 10) → one entry with `out_client_id = 4`; `multi_grant_err = 1` and stays 1 through later clean grants until reset.
- Reset mid-operation: buffer FULL, assert reset for 1 cycle with a grant present → next cycle `out_valid = 0`, `stall = 0`, `multi_grant_err = 0`; a subsequent grant to client 0 dispatches normally.
